// File: rtl/float_to_fixed_pkg.sv
// flt_fix_pkg: float16 field widths, fixed(8.8) constants and converter states
package flt_fix_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS = 15;
  localparam int FRAC_BITS = 8;
  // Exponent at which the mantissa-with-hidden-bit is already the 8.8 magnitude
  localparam logic [EXP_W-1:0] ZERO_SHIFT_EXP = EXP_W'(BIAS + MAN_W - FRAC_BITS);
  localparam logic [15:0] POS_SAT = 16'h7FFF;
  localparam logic [15:0] NEG_SAT = 16'h8000;
  typedef enum logic [2:0] {IDLE, DECODE, SHIFT, ROUND, DONE} cvt_state_t;
endpackage

// File: rtl/float_to_fixed_if.sv
// float_to_fixed_if: start/done handshake and operand/result bus of the converter
interface float_to_fixed_if;
  logic        start;
  logic [15:0] flt_in;
  logic [15:0] fix_out;
  logic        done;
  logic        busy;
  modport master(output start, flt_in, input fix_out, done, busy);
  modport slave(input start, flt_in, output fix_out, done, busy);
endinterface

// File: rtl/float_to_fixed.sv
// float_to_fixed: multi-cycle float16 to fixed(8.8) converter, one shift per cycle
module float_to_fixed
  import flt_fix_pkg::*;
(
  input logic clk,
  input logic reset,
  float_to_fixed_if.slave bus
);
  cvt_state_t r_state, w_next;
  logic [15:0] r_flt, r_fix, w_res, w_neg;
  logic [16:0] r_mag, w_rnd, w_sat_mag;
  logic [4:0] r_k, w_k, w_e;
  logic [MAN_W-1:0] w_m;
  logic r_guard, r_sticky, r_left, r_neg, w_special, w_nan, w_inc;
  assign w_e = r_flt[MAN_W +: EXP_W];
  assign w_m = r_flt[MAN_W-1:0];
  assign w_nan = (w_e == 5'd31) && (w_m != '0);
  assign w_special = (w_e <= 5'd5) || (w_e >= 5'd23);
  // Specials ride through ROUND with a magnitude that rounds to 0 or saturates
  assign w_sat_mag = (w_e <= 5'd5) ? 17'd0 : 17'h1FFFF;
  assign w_k = (w_e > ZERO_SHIFT_EXP) ? w_e - ZERO_SHIFT_EXP : ZERO_SHIFT_EXP - w_e;
  assign w_inc = r_guard & (r_sticky | r_mag[0]);
  assign w_rnd = r_mag + {16'd0, w_inc};
  assign w_neg = ~w_rnd[15:0] + 16'd1;
  assign w_res = r_neg ? ((w_rnd > 17'd32768) ? NEG_SAT : w_neg)
                       : ((w_rnd > 17'd32767) ? POS_SAT : w_rnd[15:0]);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = bus.start ? DECODE : r_state;
      DECODE:     w_next = (w_special || w_k == 5'd0) ? ROUND : SHIFT;
      SHIFT:      w_next = (r_k == 5'd1) ? ROUND : SHIFT;
      ROUND:      w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_flt <= '0;
      r_fix <= '0;
      r_mag <= '0;
      r_k <= '0;
      r_guard <= 1'b0;
      r_sticky <= 1'b0;
      r_left <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE, DONE: if (bus.start) r_flt <= bus.flt_in;
        DECODE: begin
          r_mag <= w_special ? w_sat_mag : {6'd0, 1'b1, w_m};
          r_guard <= 1'b0;
          r_sticky <= 1'b0;
          r_k <= w_k;
          r_left <= w_e > ZERO_SHIFT_EXP;
          r_neg <= r_flt[15] & ~w_nan;
        end
        SHIFT: begin
          r_k <= r_k - 5'd1;
          if (r_left) r_mag <= {r_mag[15:0], 1'b0};
          else begin
            r_sticky <= r_sticky | r_guard;
            r_guard <= r_mag[0];
            r_mag <= {1'b0, r_mag[16:1]};
          end
        end
        ROUND: r_fix <= w_res;
        default: ;
      endcase
    end
  end
  assign bus.fix_out = r_fix;
  assign bus.done = r_state == DONE;
  assign bus.busy = (r_state == DECODE) || (r_state == SHIFT) || (r_state == ROUND);
endmodule

// File: tb/tb_float_to_fixed.sv
// tb_float_to_fixed: directed vector table plus handshake and mid-operation reset sequences
module tb_float_to_fixed;
  typedef struct {
    logic [15:0] flt;
    logic [15:0] fix;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  vec_t tv[$];
  float_to_fixed_if bus();
  float_to_fixed dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  task automatic run(input logic [15:0] fin, input logic [15:0] fexp, input int lat, input int hold);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.flt_in = fin;
    @(posedge clk);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (cyc + 1 >= hold) bus.start = 1'b0;
      if (bus.done && bus.busy) chk($sformatf("busy_and_done_%h", fin), 1, 0);
      if (bus.done) break;
      @(posedge clk);
      cyc++;
    end
    chk($sformatf("latency_%h", fin), cyc, lat);
    chk($sformatf("fix_out_%h", fin), bus.fix_out, fexp);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv = '{
      '{16'h3C00, 16'h0100, 4},  '{16'hBC00, 16'hFF00, 4},  '{16'h57FF, 16'h7FF0, 6},
      '{16'h2000, 16'h0002, 11}, '{16'h1C00, 16'h0001, 12}, '{16'h1800, 16'h0000, 13},
      '{16'h1A00, 16'h0001, 13}, '{16'h1E00, 16'h0002, 12}, '{16'h1D00, 16'h0001, 12},
      '{16'h5800, 16'h7FFF, 7},  '{16'hD800, 16'h8000, 7},  '{16'h5BFF, 16'h7FFF, 7},
      '{16'h7C00, 16'h7FFF, 2},  '{16'hFC00, 16'h8000, 2},  '{16'h7E00, 16'h7FFF, 2},
      '{16'h6000, 16'h7FFF, 2},  '{16'hE000, 16'h8000, 2},  '{16'h17FF, 16'h0000, 2},
      '{16'h0000, 16'h0000, 2},  '{16'h8000, 16'h0000, 2},  '{16'h0001, 16'h0000, 2},
      '{16'h4000, 16'h0200, 3},  '{16'hC500, 16'hFB00, 2}
    };
    bus.start = 1'b0;
    bus.flt_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fix_out", bus.fix_out, 16'h0000);
    chk("reset_done", bus.done, 0);
    chk("reset_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    foreach (tv[i]) run(tv[i].flt, tv[i].fix, tv[i].lat, 1);
    // start held two cycles: one conversion, then done and result stay put
    run(16'h3C00, 16'h0100, 4, 2);
    repeat (3) begin
      @(negedge clk);
      chk("done_held", bus.done, 1);
      chk("busy_low_in_done", bus.busy, 0);
      chk("fix_out_held", bus.fix_out, 16'h0100);
    end
    run(16'h4000, 16'h0200, 3, 1);
    // reset during the right-shift phase of 0x2000
    @(negedge clk);
    bus.start = 1'b1;
    bus.flt_in = 16'h2000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("busy_in_shift", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_fix_out", bus.fix_out, 16'h0000);
    chk("async_reset_busy", bus.busy, 0);
    chk("async_reset_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b1;
    run(16'hC500, 16'hFB00, 2, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
